imm_gen_pipe: RTL and testbench

//  Registered, handshaked immediate generator for all RV32I/RV64I formats (I,S,B,U,J + shift-amount).

---
 rtl/imm_gen_pipe.sv | 206 ++++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Registered, handshaked RV32I/RV64I immediate generator.
// Decodes the immediate of the incoming instruction word and queues the
// result with its sideband tag in a 2-entry skid buffer. The main entry (M)
// drives out_*; the skid entry (K) absorbs one word of backpressure so that
// in_ready depends only on registered state.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ILL   = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_IMM_32   = 7'b0011011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_OP_32    = 7'b0111011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_shift;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  entry_t      dec;

  entry_t m_q, m_d, k_q, k_d;
  logic   m_valid_q, m_valid_d, k_valid_q, k_valid_d;
  logic   accept, pop;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Each format is assembled at 32 bits, then sign-extended to XLEN below.
  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                  in_instr[20], in_instr[30:21], 1'b0};

  // Immediate decode of the word currently on in_instr.
  always_comb begin
    dec.imm = '0;
    dec.fmt = FMT_ILL;
    dec.ill = 1'b1;
    dec.tag = in_tag;
    if (in_instr[1:0] == 2'b11) begin
      case (opcode)
        OP_LOAD, OP_JALR, OP_SYSTEM, OP_MISC_MEM: begin
          dec.imm = XLEN'($signed(imm_i));
          dec.fmt = FMT_I;
          dec.ill = 1'b0;
        end
        OP_IMM: begin
          dec.ill = 1'b0;
          if (is_shift) begin
            dec.fmt = FMT_SHAMT;
            if (XLEN == 64) dec.imm = XLEN'(in_instr[25:20]);
            else            dec.imm = XLEN'(in_instr[24:20]);
          end else begin
            dec.fmt = FMT_I;
            dec.imm = XLEN'($signed(imm_i));
          end
        end
        OP_IMM_32: begin
          if (XLEN == 64) begin
            dec.ill = 1'b0;
            if (is_shift) begin
              dec.fmt = FMT_SHAMT;
              dec.imm = XLEN'(in_instr[24:20]);
            end else begin
              dec.fmt = FMT_I;
              dec.imm = XLEN'($signed(imm_i));
            end
          end
        end
        OP_STORE: begin
          dec.imm = XLEN'($signed(imm_s));
          dec.fmt = FMT_S;
          dec.ill = 1'b0;
        end
        OP_BRANCH: begin
          dec.imm = XLEN'($signed(imm_b));
          dec.fmt = FMT_B;
          dec.ill = 1'b0;
        end
        OP_LUI, OP_AUIPC: begin
          dec.imm = XLEN'($signed(imm_u));
          dec.fmt = FMT_U;
          dec.ill = 1'b0;
        end
        OP_JAL: begin
          dec.imm = XLEN'($signed(imm_j));
          dec.fmt = FMT_J;
          dec.ill = 1'b0;
        end
        OP_OP: begin
          dec.fmt = FMT_R;
          dec.ill = 1'b0;
        end
        OP_OP_32: begin
          if (XLEN == 64) begin
            dec.fmt = FMT_R;
            dec.ill = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready = rst_n & ~k_valid_q;
  assign accept   = in_valid & in_ready;
  assign pop      = m_valid_q & out_ready;

  // Skid-buffer next state. Flush clears only the valid bits so that the
  // payload on out_* holds its last value.
  always_comb begin
    m_d       = m_q;
    k_d       = k_q;
    m_valid_d = m_valid_q;
    k_valid_d = k_valid_q;
    if (flush) begin
      m_valid_d = 1'b0;
      k_valid_d = 1'b0;
    end else if (k_valid_q) begin
      if (pop) begin
        m_d       = k_q;
        k_valid_d = 1'b0;
      end
    end else if (m_valid_q) begin
      if (accept && pop) begin
        m_d = dec;
      end else if (accept) begin
        k_d       = dec;
        k_valid_d = 1'b1;
      end else if (pop) begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      m_d       = dec;
      m_valid_d = 1'b1;
    end
  end

  // Entry registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q       <= '0;
      k_q       <= '0;
      m_valid_q <= 1'b0;
      k_valid_q <= 1'b0;
    end else begin
      m_q       <= m_d;
      k_q       <= k_d;
      m_valid_q <= m_valid_d;
      k_valid_q <= k_valid_d;
    end
  end

  assign out_valid   = m_valid_q;
  assign out_imm     = m_q.imm;
  assign out_fmt     = m_q.fmt;
  assign out_illegal = m_q.ill;
  assign out_tag     = m_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance share one
// stimulus stream and are compared each cycle against a queue-based model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_tag;

  logic        r32, v32, il32, r64, v64, il64;
  logic [31:0] imm32, tag32, tag64;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(r32), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(v32), .out_ready(out_ready), .out_imm(imm32),
    .out_fmt(fmt32), .out_illegal(il32), .out_tag(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(r64), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(v64), .out_ready(out_ready), .out_imm(imm64),
    .out_fmt(fmt64), .out_illegal(il64), .out_tag(tag64)
  );

  typedef struct {
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        ill32;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ill64;
    logic [31:0] tag;
  } exp_t;

  exp_t q[$];
  exp_t last;

  // Reference decode built from shifts and masks on a sign-extended word.
  function automatic void ref_dec(input logic [31:0] w, input bit x64,
                                  output logic [63:0] imm,
                                  output logic [2:0] fmt, output logic ill);
    longint s, hi, umask;
    logic [2:0] f3;
    s     = longint'(signed'(w));
    umask = -4096;
    f3    = w[14:12];
    imm = '0; fmt = 3'd7; ill = 1'b1;
    if (w[1:0] == 2'b11) begin
      case (w[6:0])
        7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
          hi = s >>> 20; imm = hi; fmt = 3'd1; ill = 1'b0;
        end
        7'b0010011: begin
          ill = 1'b0;
          if (f3 == 3'd1 || f3 == 3'd5) begin
            fmt = 3'd6;
            imm = x64 ? longint'(w[25:20]) : longint'(w[24:20]);
          end else begin
            hi = s >>> 20; imm = hi; fmt = 3'd1;
          end
        end
        7'b0011011: begin
          if (x64) begin
            ill = 1'b0;
            if (f3 == 3'd1 || f3 == 3'd5) begin
              fmt = 3'd6; imm = longint'(w[24:20]);
            end else begin
              hi = s >>> 20; imm = hi; fmt = 3'd1;
            end
          end
        end
        7'b0100011: begin
          hi = s >>> 25;
          imm = (hi << 5) | longint'(w[11:7]); fmt = 3'd2; ill = 1'b0;
        end
        7'b1100011: begin
          hi = s >>> 31;
          imm = (hi << 12) | (longint'(w[7]) << 11) | (longint'(w[30:25]) << 5)
                | (longint'(w[11:8]) << 1);
          fmt = 3'd3; ill = 1'b0;
        end
        7'b0110111, 7'b0010111: begin
          imm = s & umask; fmt = 3'd4; ill = 1'b0;
        end
        7'b1101111: begin
          hi = s >>> 31;
          imm = (hi << 20) | (longint'(w[19:12]) << 12) | (longint'(w[20]) << 11)
                | (longint'(w[30:21]) << 1);
          fmt = 3'd5; ill = 1'b0;
        end
        7'b0110011: begin
          fmt = 3'd0; ill = 1'b0;
        end
        7'b0111011: begin
          if (x64) begin fmt = 3'd0; ill = 1'b0; end
        end
        default: ;
      endcase
    end
  endfunction

  function automatic exp_t make_exp(input logic [31:0] w, input logic [31:0] t);
    exp_t e;
    logic [63:0] i32;
    ref_dec(w, 1'b0, i32, e.fmt32, e.ill32);
    e.imm32 = i32[31:0];
    ref_dec(w, 1'b1, e.imm64, e.fmt64, e.ill64);
    e.tag = t;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic check_all();
    exp_t cur;
    logic exp_ready, exp_valid;
    exp_ready = rst_n && (q.size() < 2);
    exp_valid = (q.size() > 0);
    cur = exp_valid ? q[0] : last;
    check("in_ready32", 64'(r32), 64'(exp_ready));
    check("in_ready64", 64'(r64), 64'(exp_ready));
    check("out_valid32", 64'(v32), 64'(exp_valid));
    check("out_valid64", 64'(v64), 64'(exp_valid));
    check("imm32", 64'(imm32), 64'(cur.imm32));
    check("imm64", imm64, cur.imm64);
    check("fmt32", 64'(fmt32), 64'(cur.fmt32));
    check("fmt64", 64'(fmt64), 64'(cur.fmt64));
    check("tag32", 64'(tag32), 64'(cur.tag));
    check("tag64", 64'(tag64), 64'(cur.tag));
    if (exp_valid) begin
      check("ill32", 64'(il32), 64'(cur.ill32));
      check("ill64", 64'(il64), 64'(cur.ill64));
    end
  endtask

  // Advance one clock: update the model with the inputs seen at the edge,
  // then compare the DUT outputs 1 time unit later.
  task automatic tick();
    bit acc, pp;
    @(posedge clk);
    acc = in_valid && rst_n && (q.size() < 2);
    pp  = rst_n && (q.size() > 0) && out_ready;
    if (flush) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(make_exp(in_instr, in_tag));
    end
    if (q.size() > 0) last = q[0];
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] t);
    in_valid = v; in_instr = w; in_tag = t;
  endtask

  logic [6:0] ops [15];

  initial begin
    ops = '{7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111, 7'b0010011,
            7'b0011011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
            7'b1101111, 7'b0110011, 7'b0111011, 7'b0000000, 7'b1111111};
    last = '{default: '0};
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_tag = '0;

    // Reset state
    #2 check_all();
    check("rst_fmt32", 64'(fmt32), 64'd0);
    check("rst_ill32", 64'(il32), 64'd0);
    #10 rst_n = 1'b1;
    tick();

    // Directed decode vectors, one per cycle with the consumer ready
    drive(1, 32'hFFC12083, 32'h100); tick();
    check("lw_imm", 64'(imm32), 64'hFFFFFFFC); check("lw_fmt", 64'(fmt32), 64'd1);
    check("lw_imm64", imm64, 64'hFFFFFFFFFFFFFFFC);
    drive(1, 32'hFE112E23, 32'h104); tick();
    check("sw_imm", 64'(imm32), 64'hFFFFFFFC); check("sw_fmt", 64'(fmt32), 64'd2);
    drive(1, 32'hFE000CE3, 32'h108); tick();
    check("beq_imm", 64'(imm32), 64'hFFFFFFF8); check("beq_fmt", 64'(fmt32), 64'd3);
    drive(1, 32'h123452B7, 32'h10C); tick();
    check("lui_imm", 64'(imm32), 64'h12345000); check("lui_fmt", 64'(fmt32), 64'd4);
    drive(1, 32'h0010006F, 32'h110); tick();
    check("jal_imm", 64'(imm32), 64'h00000800); check("jal_fmt", 64'(fmt32), 64'd5);
    drive(1, 32'h4010D093, 32'h114); tick();
    check("srai_imm", 64'(imm32), 64'h1); check("srai_fmt", 64'(fmt32), 64'd6);
    drive(1, 32'h002081B3, 32'h118); tick();
    check("add_imm", 64'(imm32), 64'h0); check("add_fmt", 64'(fmt32), 64'd0);
    check("add_ill", 64'(il32), 64'd0);
    drive(1, 32'h00000000, 32'h11C); tick();
    check("zero_fmt", 64'(fmt32), 64'd7); check("zero_ill", 64'(il32), 64'd1);
    drive(1, 32'h0000007F, 32'h120); tick();
    check("ff_fmt", 64'(fmt32), 64'd7); check("ff_ill", 64'(il32), 64'd1);
    check("ff_imm", 64'(imm32), 64'h0);
    drive(1, 32'h0010809B, 32'h124); tick();
    check("addiw64_imm", imm64, 64'h1); check("addiw64_fmt", 64'(fmt64), 64'd1);
    check("addiw32_fmt", 64'(fmt32), 64'd7);
    drive(0, '0, '0); tick();

    // Backpressure: A,B fill both entries, C waits
    out_ready = 1'b0;
    drive(1, 32'hFFC12083, 32'hA); tick();
    drive(1, 32'hFE112E23, 32'hB); tick();
    check("full_ready", 64'(r32), 64'd0);
    drive(1, 32'h123452B7, 32'hC); tick();
    check("stall_tag", 64'(tag32), 64'hA);
    tick();
    check("stall_imm", 64'(imm32), 64'hFFFFFFFC);
    out_ready = 1'b1; tick();
    check("order_B", 64'(tag32), 64'hB);
    tick();
    check("order_C", 64'(tag32), 64'hC);
    drive(0, '0, '0); tick();

    // Flush at occupancy 2 with a word offered in the same cycle
    out_ready = 1'b0;
    drive(1, 32'h0010006F, 32'hD0); tick();
    drive(1, 32'hFE000CE3, 32'hD1); tick();
    flush = 1'b1; drive(1, 32'h4010D093, 32'hD2); tick();
    check("flush_valid", 64'(v32), 64'd0); check("flush_ready", 64'(r32), 64'd1);
    flush = 1'b0; drive(0, '0, '0); out_ready = 1'b1; tick();
    check("flush_drop", 64'(v32), 64'd0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    drive(1, 32'hFFC12083, 32'hE0); tick();
    drive(1, 32'hFE112E23, 32'hE1); tick();
    rst_n = 1'b0;
    q.delete(); last = '{default: '0};
    #1 check_all();
    #2 rst_n = 1'b1;
    drive(0, '0, '0); out_ready = 1'b1; tick();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 14)];
      drive(logic'($urandom_range(0, 3) != 0), w, $urandom);
      out_ready = logic'($urandom_range(0, 2) != 0);
      flush = logic'($urandom_range(0, 19) == 0);
      tick();
    end
    flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
